// File: rtl/stream_serializer_if.sv
// Handshake and serial-output bundle between an upstream word source and stream_serializer.
// The master side supplies words and flush; the slave side is the serializer.
interface stream_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic             stream;
   logic             stream_valid;
   logic             busy;

   modport master (
      output in_data, in_valid, flush,
      input  in_ready, stream, stream_valid, busy
   );

   modport slave (
      input  in_data, in_valid, flush,
      output in_ready, stream, stream_valid, busy
   );
endinterface

// File: rtl/stream_serializer.sv
// Parallel-to-serial front end feeding the three-ones detector.
// Words arrive on a valid/ready handshake and leave one bit per clock, back-to-back without gaps.
//
// state   | meaning
// S_idle  | no word in flight; stream held at IDLE_BIT
// S_shift | head of shift_q is on stream; bit_cnt_q bits remain after it
module stream_serializer #(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic                clk,
   input  logic                rst_b,
   stream_serializer_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   typedef enum logic {
      S_idle  = 1'b0,
      S_shift = 1'b1
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    bit_cnt_q;

   logic             head_bit;
   logic             accept;

   assign head_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

   // A new word may be taken while the last bit of the current word is on stream.
   assign bus.in_ready     = !bus.flush &&
                             (state_q == S_idle || bit_cnt_q == '0);
   assign accept           = bus.in_valid && bus.in_ready;
   assign bus.stream_valid = (state_q == S_shift);
   assign bus.busy         = (state_q == S_shift);
   assign bus.stream       = (state_q == S_shift) ? head_bit : IDLE_BIT;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= S_idle;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (bus.flush) begin
         state_q   <= S_idle;
         bit_cnt_q <= '0;
      end else begin
         case (state_q)
            S_idle: begin
               if (accept) begin
                  shift_q   <= bus.in_data;
                  bit_cnt_q <= CNT_LOAD;
                  state_q   <= S_shift;
               end
            end
            S_shift: begin
               if (bit_cnt_q != '0) begin
                  shift_q   <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                  bit_cnt_q <= bit_cnt_q - CW'(1);
               end else if (accept) begin
                  shift_q   <= bus.in_data;
                  bit_cnt_q <= CNT_LOAD;
               end else begin
                  state_q   <= S_idle;
               end
            end
            default: begin
               state_q   <= S_idle;
               bit_cnt_q <= '0;
            end
         endcase
      end
   end
endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Parallel-to-serial front end that produces the 1-bit `stream` consumed by the downstream three-ones detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- Back-to-back words are emitted gaplessly.
- Outside a word, `stream` is driven to a fixed idle level so the detector sees no spurious ones.

Parameters:
WIDTH, 8, bits per input word; legal range 1 and up.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
IDLE_BIT, 1'b0, value driven on `stream` when no word is being shifted.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_b  input  1  asynchronous, active-low reset.
in_data  input  WIDTH  word to serialize; sampled only on a handshake.
in_valid  input  1  upstream has a word on in_data.
in_ready  output  1  block can accept a word this cycle.
flush  input  1  synchronous abort of the word in progress.
stream  output  1  serial bit to the detector.
stream_valid  output  1  `stream` carries a data bit this cycle.
busy  output  1  a word is in progress; equals stream_valid.

Behaviour:
- The clock is `clk`. Reset is asynchronous and active-low on `rst_b`; there is one clock domain.
- State is two-state enumerated: S_idle and S_shift. Registers are shift_reg[WIDTH], bit_cnt[$clog2(WIDTH) or 1 bit minimum], and state.
- Reset (rst_b low, asynchronous) sets:
  - state = S_idle, shift_reg = 0, bit_cnt = 0.
  - Outputs: stream = IDLE_BIT, stream_valid = 0, busy = 0, in_ready = !flush.
- Outputs are combinational from registers and flush only:
  - stream = head bit of shift_reg in S_shift; otherwise IDLE_BIT.
  - stream_valid = busy = (state == S_shift).
  - in_ready = !flush && (state == S_idle || (state == S_shift && bit_cnt == 0)).
- Handshake: a word is accepted on a rising edge where in_valid && in_ready.
  - in_data is captured into shift_reg and bit_cnt is loaded with WIDTH-1.
  - in_valid without in_ready has no effect. Upstream must hold the word; there is no internal buffering.
- Latency: for a word accepted at edge N, its first bit is on `stream` in the cycle following edge N. The last bit is on `stream` in the cycle following edge N+WIDTH-1.
- Transitions in priority order:
  - flush = 1: next state = S_idle and bit_cnt = 0. Any word in progress is discarded. in_ready is low, so no accept occurs in that cycle.
  - S_idle with handshake: go to S_shift.
  - S_idle without handshake: stay in S_idle.
  - S_shift with bit_cnt != 0: shift one position toward the head (left when MSB_FIRST=1, right when 0) and decrement bit_cnt.
  - S_shift with bit_cnt == 0 and handshake: reload and stay in S_shift. This gives a gapless back-to-back stream.
  - S_shift with bit_cnt == 0 and no handshake: go to S_idle.
- WIDTH = 1: bit_cnt is always 0, so in_ready is high every cycle when not flushing and one word streams per cycle.
- Vacated shift positions fill with 0. This value is never visible on `stream` because the head bit is only used while bits remain.
- Reset mid-word: the word is dropped immediately, asynchronously. Nothing is resumed after release.
- bit_cnt never wraps. It is only decremented when nonzero.

Test Plan:
- Reset, then one word 8'b1110_0000 with MSB_FIRST=1:
  - in_ready = 1 at the accept edge.
  - stream = 1,1,1,0,0,0,0,0 over the next 8 cycles with stream_valid high throughout.
  - Afterwards stream_valid = 0, stream = 0, in_ready = 1.
- in_valid held high with words 8'hA5 then 8'h3C:
  - Exactly 16 consecutive stream_valid cycles carrying 10100101 00111100.
  - in_ready is high only at the start and in the 8th bit cycle.
- in_valid high mid-word (bit_cnt = 5) with a new word:
  - The new word is not accepted until bit_cnt = 0.
  - The first word's bits are unchanged.
- flush asserted on the 3rd bit of 8'hFF:
  - 3 ones appear, then stream = 0 and stream_valid = 0 from the next cycle.
  - in_ready is 0 during the flush cycle and 1 the cycle after.
- rst_b pulled low asynchronously mid-word (between edges):
  - stream_valid drops to 0 and stream goes to IDLE_BIT immediately.
  - After release, a fresh 8'h81 streams 1,0,0,0,0,0,0,1.
- MSB_FIRST=0, WIDTH=4, word 4'b0011:
  - stream = 1,1,0,0.
  - WIDTH=1 run: in_ready is constantly 1 and stream equals in_data delayed by one cycle.
